stream_controller_fork_join: RTL
================================

# stream_controller_fork_join

Parametrised join/fork handshake controller for the stream pipeline. It joins NUM_INPUTS valid/ready input streams and forks into NUM_OUTPUTS output streams, with per-cycle consume/produce masks chosen by the stage logic. Each output owns a registered valid, so outputs drain independently (eager fork). A saturating stall counter supports performance debug.

## Interface
- NUM_INPUTS, default 2: number of input streams, ≥1.
- NUM_OUTPUTS, default 2: number of output streams, ≥1.
- PIPELINE_READY, default 1: 1 = an output slot may be refilled in the cycle it drains; 0 = a slot is free only when empty, which breaks the ready-to-ready combinational path.
- STALL_WIDTH, default 16: stall counter width, ≥1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- inputs_valid  in  NUM_INPUTS  per-input valid.
- inputs_ready  out  NUM_INPUTS  per-input ready.
- outputs_valid  out  NUM_OUTPUTS  per-output valid, registered.
- outputs_ready  in  NUM_OUTPUTS  per-output ready.
- consume  in  NUM_INPUTS  inputs the stage needs this cycle.
- produce  in  NUM_OUTPUTS  outputs the stage writes this cycle.
- enable  out  1  stage fires this cycle; the user loads output data registers on it.
- stall_clear  in  1  synchronous clear of stall_count.
- stall_count  out  STALL_WIDTH  saturating count of stalled cycles.

## Operation
- free[j] = !outputs_valid[j] | outputs_ready[j] when PIPELINE_READY=1.
- free[j] = !outputs_valid[j] when PIPELINE_READY=0.
- enable = AND over i of (inputs_valid[i] | !consume[i]), AND over j of (free[j] | !produce[j]). Combinational.
- With consume=0 and produce=0, enable=1. This is legal and acts as a no-op fire.
- inputs_ready[i] = enable & consume[i]. An input transfers when inputs_valid[i] & inputs_ready[i].
- inputs_ready never depends on an unconsumed input's valid. An input with consume=0 sees ready=0.
- Per output j, each rising edge:
  - if enable & produce[j]: outputs_valid[j] ← 1;
  - else if outputs_ready[j]: outputs_valid[j] ← 0;
  - else hold.
- Outputs are independent. One output may drain while a sibling still holds. A new fire producing j waits until free[j].
- Stall condition = !enable & (OR over i of (inputs_valid[i] & consume[i])).
- stall_count update, in priority order:
  - stall_clear → 0, overriding a simultaneous stall;
  - stall and count < 2^STALL_WIDTH−1 → +1;
  - otherwise hold. The count saturates and never wraps.
- consume and produce may change every cycle. The controller keeps no state about them.

## Timing
- Reset (rst=0), asynchronous, also when asserted mid-transfer: outputs_valid=0 and stall_count=0 immediately.
- inputs_ready and enable are then driven combinationally from the held-low valids, i.e. ready iff the consumed inputs are valid.
- Latency is 1 cycle: a fire at edge N gives outputs_valid[j]=1 after edge N.
- Throughput with PIPELINE_READY=1: 1 fire per cycle with all consumers ready.
- Throughput with PIPELINE_READY=0: one fire every 2 cycles per output.
- Combinational paths:
  - inputs_valid → enable/inputs_ready;
  - outputs_ready → enable/inputs_ready only when PIPELINE_READY=1.
- No path exists from outputs_valid to inputs_valid.
- A simultaneous drain and refill of j in one cycle keeps outputs_valid[j]=1. That counts as two transfers: old data out, new data in.
- Release from reset is synchronous to clk at the user level. The first fire can occur in the first cycle with rst=1.

## Test plan
- Reset/basic: rst low, then high; consume=2'b11, both inputs valid, produce=2'b11, outputs_ready=2'b11 → enable=1, inputs_ready=2'b11 every cycle, outputs_valid=2'b11 from the next cycle, stall_count stays 0.
- Join stall: consume=2'b11, inputs_valid=2'b01 for 5 cycles, then 2'b11 → enable=0 and inputs_ready=0 for 5 cycles, stall_count=5, then enable=1 for one cycle.
- Eager fork: fire once with produce=2'b11, outputs_ready=2'b01 for 3 cycles, then 2'b10 → outputs_valid goes 11→10, is held 3 cycles, then →00. A second fire producing output 1 is blocked until output 1 drains.
- PIPELINE_READY=0: outputs_ready held at 1, continuous valid inputs → enable alternates 1,0,1,0. With PIPELINE_READY=1 the same stimulus gives enable=1 every cycle.
- Saturation/clear: STALL_WIDTH=3, 10 stall cycles → stall_count=7. stall_clear asserted in a stall cycle → 0 next cycle, then 1 after the following stall cycle.
- Reset mid-transfer: outputs_valid=2'b11 with outputs_ready=0, assert rst between edges → outputs_valid=0 and stall_count=0 before the next edge, with no ready or enable glitch dependent on clk.

Source files
------------

// File: rtl/stream_controller_fork_join.sv
// Join/fork valid-ready handshake controller: joins consumed inputs, forks into
// independently draining registered output valids, with a saturating stall counter.

module stream_controller_fork_join_slot #(
    parameter bit PIPELINE_READY = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic fire_i,
    input  logic produce_i,
    input  logic ready_i,
    output logic valid_o,
    output logic free_o
);
    logic valid_q, valid_d;

    always_comb begin
        valid_d = valid_q;
        if (fire_i && produce_i) valid_d = 1'b1;
        else if (ready_i)        valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= 1'b0;
        else      valid_q <= valid_d;
    end

    // PIPELINE_READY=0 drops outputs_ready from the free term, cutting the ready->ready path.
    if (PIPELINE_READY) begin : g_pipe
        assign free_o = !valid_q || ready_i;
    end else begin : g_nopipe
        assign free_o = !valid_q;
    end

    assign valid_o = valid_q;
endmodule

module stream_controller_fork_join #(
    parameter int unsigned NUM_INPUTS     = 2,
    parameter int unsigned NUM_OUTPUTS    = 2,
    parameter bit          PIPELINE_READY = 1'b1,
    parameter int unsigned STALL_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_INPUTS-1:0]  inputs_valid,
    output logic [NUM_INPUTS-1:0]  inputs_ready,
    output logic [NUM_OUTPUTS-1:0] outputs_valid,
    input  logic [NUM_OUTPUTS-1:0] outputs_ready,
    input  logic [NUM_INPUTS-1:0]  consume,
    input  logic [NUM_OUTPUTS-1:0] produce,
    output logic                   enable,
    input  logic                   stall_clear,
    output logic [STALL_WIDTH-1:0] stall_count
);
    logic [NUM_OUTPUTS-1:0] free;
    logic                   stall;
    logic [STALL_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_out
        stream_controller_fork_join_slot #(
            .PIPELINE_READY(PIPELINE_READY)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .fire_i   (enable),
            .produce_i(produce[j]),
            .ready_i  (outputs_ready[j]),
            .valid_o  (outputs_valid[j]),
            .free_o   (free[j])
        );
    end

    // Unconsumed inputs and unproduced outputs never block a fire.
    assign enable       = (&(inputs_valid | ~consume)) && (&(free | ~produce));
    assign inputs_ready = {NUM_INPUTS{enable}} & consume;
    assign stall        = !enable && (|(inputs_valid & consume));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clear)
            stall_cnt_d = '0;
        else if (stall && (stall_cnt_q != {STALL_WIDTH{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
endmodule
